// File: rtl/lsu_bus_bridge_pkg.sv
// Shared types for the LSU-to-data-bus bridge: FSM state encodings and the
// registered bus command payload.
package lsu_bus_bridge_pkg;

  typedef enum logic [2:0] {
    LSB_IDLE  = 3'd0,
    LSB_CMD   = 3'd1,
    LSB_WAIT  = 3'd2,
    LSB_RESP  = 3'd3,
    LSB_BLANK = 3'd4
  } lsb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  sel;
  } bus_cmd_t;

endpackage

// File: rtl/lsu_bus_bridge.sv
// Bridges one exu_mem load/store at a time onto a valid/ready data bus, with a
// response timeout, local misalignment errors and discard of late responses.
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_sel_i,
  input  logic        req_misalign_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        bus_cmd_valid_o,
  input  logic        bus_cmd_ready_i,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_rsp_valid_i,
  output logic        bus_rsp_ready_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        stray_rsp_o
);

  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'(TIMEOUT_CYC - 1);

  lsb_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  bus_cmd_t         cmd_q, cmd_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             stray_owed_q, stray_owed_d;
  logic             timer_expired;
  logic             stray_drop;

  assign timer_expired = (TIMEOUT_CYC != 0) && (timer_q == EXPIRE_AT);
  // A late response can only show up outside WAIT, because IDLE refuses new work while one is owed.
  assign stray_drop    = stray_owed_q && bus_rsp_valid_i && (state_q != LSB_WAIT);

  // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LSB_IDLE;
      timer_q      <= '0;
      // NOTE: the payload registers are reset too, so bus_* and rsp_* read 0 straight out of reset.
      cmd_q        <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      stray_owed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cmd_q        <= cmd_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      stray_owed_q <= stray_owed_d;
    end
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case can infer a latch.
    state_d      = state_q;
    timer_d      = timer_q;
    cmd_d        = cmd_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    stray_owed_d = stray_owed_q;
    if (stray_drop) begin
      stray_owed_d = 1'b0;
    end
    case (state_q)
      LSB_IDLE: begin
        if (req_valid_i && !stray_owed_q) begin
          if (req_misalign_i) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = LSB_RESP;
          end else begin
            cmd_d   = '{addr: req_addr_i, wdata: req_wdata_i, we: req_we_i, sel: req_sel_i};
            timer_d = '0;
            state_d = LSB_CMD;
          end
        end
      end
      LSB_CMD: begin
        timer_d = timer_q + CNT_W'(1);
        if (bus_cmd_ready_i) begin
          state_d = LSB_WAIT;
        end else if (timer_expired) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = LSB_RESP;
        end
      end
      LSB_WAIT: begin
        timer_d = timer_q + CNT_W'(1);
        if (bus_rsp_valid_i) begin
          rsp_rdata_d = cmd_q.we ? 32'h0 : bus_rdata_i;
          rsp_err_d   = bus_err_i;
          state_d     = LSB_RESP;
        end else if (timer_expired) begin
          rsp_rdata_d  = '0;
          rsp_err_d    = 1'b1;
          stray_owed_d = 1'b1;
          state_d      = LSB_RESP;
        end
      end
      LSB_RESP: begin
        if (rsp_ready_i) begin
          state_d = LSB_BLANK;
        end
      end
      LSB_BLANK: state_d = LSB_IDLE;
      default:   state_d = LSB_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o     = 1'b0;
    bus_cmd_valid_o = 1'b0;
    bus_rsp_ready_o = stray_owed_q;
    rsp_valid_o     = 1'b0;
    case (state_q)
      LSB_IDLE: req_ready_o     = !stray_owed_q;
      LSB_CMD:  bus_cmd_valid_o = 1'b1;
      LSB_WAIT: bus_rsp_ready_o = 1'b1;
      LSB_RESP: rsp_valid_o     = 1'b1;
      default:  ;
    endcase
  end

  assign bus_addr_o  = cmd_q.addr;
  assign bus_wdata_o = cmd_q.wdata;
  assign bus_we_o    = cmd_q.we;
  assign bus_sel_o   = cmd_q.sel;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign stray_rsp_o = stray_drop;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares each accepted response.
module tb_lsu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        req_we_i;
  logic [3:0]  req_sel_i;
  logic        req_misalign_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        bus_cmd_valid_o, bus_cmd_ready_i;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic        bus_rsp_valid_i, bus_rsp_ready_o;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;
  logic        stray_rsp_o;

  int          checks = 0;
  int          failures = 0;
  int          cmd_cycles = 0;
  logic [32:0] exp_q[$];

  lsu_bus_bridge #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_we_i(req_we_i), .req_sel_i(req_sel_i), .req_misalign_i(req_misalign_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .bus_cmd_valid_o(bus_cmd_valid_o), .bus_cmd_ready_i(bus_cmd_ready_i),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_rsp_valid_i(bus_rsp_valid_i), .bus_rsp_ready_o(bus_rsp_ready_o),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
    .stray_rsp_o(stray_rsp_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                       input logic [3:0] sel, input logic mis);
    req_valid_i    = 1'b1;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_we_i       = we;
    req_sel_i      = sel;
    req_misalign_i = mis;
  endtask

  // Waits (bounded) for the response cycle, then walks through BLANK and drops the request.
  task automatic finish_txn(input string name, output int lat);
    lat = 0;
    @(negedge clk);
    while (rsp_valid_o !== 1'b1 && lat < 30) begin
      tick();
      lat++;
      @(negedge clk);
    end
    check({name, "_rsp_seen"}, rsp_valid_o, 1'b1);
    check({name, "_rsp_req_ready"}, req_ready_o, 1'b0);
    tick();
    @(negedge clk);
    check({name, "_blank"}, {rsp_valid_o, req_ready_o}, 2'b00);
    tick();
    req_valid_i = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus_cmd_valid_o === 1'b1) cmd_cycles++;
    if (rsp_valid_o && rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid_o, 1'b0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_payload", {rsp_rdata_o, rsp_err_o}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cmd_before;
    rst = 1'b1;
    req_valid_i = 0; req_addr_i = 0; req_wdata_i = 0; req_we_i = 0; req_sel_i = 0;
    req_misalign_i = 0; rsp_ready_i = 1; bus_cmd_ready_i = 0; bus_rsp_valid_i = 0;
    bus_rdata_i = 0; bus_err_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_ctrl", {req_ready_o, bus_cmd_valid_o, rsp_valid_o, bus_rsp_ready_o, stray_rsp_o},
          5'b10000);
    check("reset_regs", {bus_addr_o, rsp_rdata_o, rsp_err_o}, 65'h0);

    // Load, zero-wait fabric
    tick();
    issue(32'h2000_0004, 32'h0, 1'b0, 4'hF, 1'b0);
    bus_cmd_ready_i = 1'b1;
    exp_q.push_back({32'hDEAD_BEEF, 1'b0});
    @(negedge clk);
    check("t1_c0_ready", req_ready_o, 1'b1);
    tick();
    @(negedge clk);
    check("t1_c1_cmd", {bus_cmd_valid_o, bus_we_o, bus_addr_o, req_ready_o}, {1'b1, 1'b0, 32'h2000_0004, 1'b0});
    tick();
    bus_rsp_valid_i = 1'b1;
    bus_rdata_i     = 32'hDEAD_BEEF;
    @(negedge clk);
    check("t1_c2_wait", {bus_rsp_ready_o, bus_cmd_valid_o, req_ready_o}, 3'b100);
    tick();
    bus_rsp_valid_i = 1'b0;
    finish_txn("t1", lat);
    check("t1_latency", lat, 0);
    @(negedge clk);
    check("t1_next_accept", req_ready_o, 1'b1);

    // Store with cmd_ready delayed 3 cycles; accept lands on the timer-expiry cycle
    tick();
    issue(32'h10, 32'h0000_AB00, 1'b1, 4'b0010, 1'b0);
    bus_cmd_ready_i = 1'b0;
    exp_q.push_back({32'h0, 1'b0});
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_cmd_ready_i = 1'b1;
      @(negedge clk);
      check("t2_payload", {bus_cmd_valid_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o},
            {1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000_AB00});
      tick();
    end
    bus_cmd_ready_i = 1'b0;
    bus_rsp_valid_i = 1'b1;
    bus_rdata_i     = 32'h1234_5678;
    @(negedge clk);
    check("t2_wait", {bus_rsp_ready_o, bus_cmd_valid_o}, 2'b10);
    tick();
    bus_rsp_valid_i = 1'b0;
    finish_txn("t2", lat);
    check("t2_latency", lat, 0);

    // Misaligned load: answered locally, no bus command
    cmd_before = cmd_cycles;
    issue(32'h3, 32'h0, 1'b0, 4'hF, 1'b1);
    exp_q.push_back({32'h0, 1'b1});
    tick();
    finish_txn("t3", lat);
    check("t3_latency", lat, 0);
    check("t3_no_cmd", cmd_cycles - cmd_before, 0);

    // Timeout with no response, then a late stray response
    issue(32'h40, 32'h0, 1'b0, 4'hF, 1'b0);
    bus_cmd_ready_i = 1'b1;
    exp_q.push_back({32'h0, 1'b1});
    tick();
    finish_txn("t4", lat);
    check("t4_timeout_latency", lat, 4);
    issue(32'h44, 32'h0, 1'b0, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t4_owed_block", {req_ready_o, bus_rsp_ready_o, stray_rsp_o}, 3'b010);
      tick();
    end
    bus_rsp_valid_i = 1'b1;
    bus_rdata_i     = 32'h0000_0BAD;
    @(negedge clk);
    check("t4_stray_pulse", {stray_rsp_o, req_ready_o}, 2'b10);
    tick();
    bus_rsp_valid_i = 1'b0;
    exp_q.push_back({32'hCAFE_F00D, 1'b0});
    @(negedge clk);
    check("t4_after_stray", {stray_rsp_o, req_ready_o, bus_rsp_ready_o}, 3'b010);
    tick();
    tick();
    bus_rsp_valid_i = 1'b1;
    bus_rdata_i     = 32'hCAFE_F00D;
    tick();
    bus_rsp_valid_i = 1'b0;
    finish_txn("t4b", lat);
    check("t4b_latency", lat, 0);

    // Bus error on load, with response backpressure
    issue(32'h80, 32'h0, 1'b0, 4'hF, 1'b0);
    exp_q.push_back({32'h0BAD_C0DE, 1'b1});
    tick();
    tick();
    bus_rsp_valid_i = 1'b1;
    bus_rdata_i     = 32'h0BAD_C0DE;
    bus_err_i       = 1'b1;
    tick();
    bus_rsp_valid_i = 1'b0;
    bus_err_i       = 1'b0;
    rsp_ready_i     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t5_hold", {rsp_valid_o, rsp_rdata_o, rsp_err_o}, {1'b1, 32'h0BAD_C0DE, 1'b1});
      tick();
    end
    rsp_ready_i = 1'b1;
    finish_txn("t5", lat);
    check("t5_latency", lat, 0);

    // Reset pulse during WAIT abandons the transaction
    issue(32'h100, 32'h0, 1'b0, 4'hF, 1'b0);
    tick();
    tick();
    @(negedge clk);
    check("t6_in_wait", {bus_rsp_ready_o, bus_cmd_valid_o}, 2'b10);
    req_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_after_rst", {req_ready_o, rsp_valid_o, bus_cmd_valid_o, bus_rsp_ready_o}, 4'b1000);
    tick();
    issue(32'h200, 32'h0, 1'b0, 4'hF, 1'b0);
    exp_q.push_back({32'h1122_3344, 1'b0});
    tick();
    tick();
    bus_rsp_valid_i = 1'b1;
    bus_rdata_i     = 32'h1122_3344;
    tick();
    bus_rsp_valid_i = 1'b0;
    finish_txn("t6", lat);
    check("t6_latency", lat, 0);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
